// File: rtl/pipeline_id_ex_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds on stall, inserts a zeroed bubble on flush, and counts bubbles with saturation.
module pipeline_id_ex_reg #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int WB_W    = 2,
  parameter int M_W     = 2,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          valid_i,
  input  logic [WB_W+M_W+ALUOP_W+1:0]   ctrl_i,
  input  logic [DATA_W-1:0]             pc_add4_i,
  input  logic [DATA_W-1:0]             rs_data_i,
  input  logic [DATA_W-1:0]             rt_data_i,
  input  logic [DATA_W-1:0]             imm_i,
  input  logic [RA_W-1:0]               rs_addr_i,
  input  logic [RA_W-1:0]               rt_addr_i,
  input  logic [RA_W-1:0]               rd_addr_i,
  output logic                          valid_o,
  output logic [WB_W-1:0]               wb_o,
  output logic [M_W-1:0]                m_o,
  output logic                          alu_src_o,
  output logic [ALUOP_W-1:0]            alu_op_o,
  output logic                          reg_dst_o,
  output logic [DATA_W-1:0]             pc_add4_o,
  output logic [DATA_W-1:0]             rs_data_o,
  output logic [DATA_W-1:0]             rt_data_o,
  output logic [DATA_W-1:0]             imm_o,
  output logic [RA_W-1:0]               rs_addr_o,
  output logic [RA_W-1:0]               rt_addr_o,
  output logic [RA_W-1:0]               rd_addr_o,
  output logic [RA_W-1:0]               dst_addr_o,
  output logic [CNT_W-1:0]              bubble_cnt_o
);

  localparam int CW = WB_W + M_W + ALUOP_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_r;
  logic [CW-1:0]     ctrl_r;
  logic [DATA_W-1:0] pc_add4_r;
  logic [DATA_W-1:0] rs_data_r;
  logic [DATA_W-1:0] rt_data_r;
  logic [DATA_W-1:0] imm_r;
  logic [RA_W-1:0]   rs_addr_r;
  logic [RA_W-1:0]   rt_addr_r;
  logic [RA_W-1:0]   rd_addr_r;
  logic [RA_W-1:0]   dst_addr_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [RA_W-1:0]   dst_sel_s;

  // Resolve the destination register from the incoming RegDst bit
  always_comb begin
    dst_sel_s = rt_addr_i;
    if (ctrl_i[0]) begin
      dst_sel_s = rd_addr_i;
    end else begin
      dst_sel_s = rt_addr_i;
    end
  end

  // Stage register: flush beats stall beats load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r      <= 1'b0;
      ctrl_r       <= {CW{1'b0}};
      pc_add4_r    <= {DATA_W{1'b0}};
      rs_data_r    <= {DATA_W{1'b0}};
      rt_data_r    <= {DATA_W{1'b0}};
      imm_r        <= {DATA_W{1'b0}};
      rs_addr_r    <= {RA_W{1'b0}};
      rt_addr_r    <= {RA_W{1'b0}};
      rd_addr_r    <= {RA_W{1'b0}};
      dst_addr_r   <= {RA_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      valid_r      <= 1'b0;
      ctrl_r       <= {CW{1'b0}};
      pc_add4_r    <= {DATA_W{1'b0}};
      rs_data_r    <= {DATA_W{1'b0}};
      rt_data_r    <= {DATA_W{1'b0}};
      imm_r        <= {DATA_W{1'b0}};
      rs_addr_r    <= {RA_W{1'b0}};
      rt_addr_r    <= {RA_W{1'b0}};
      rd_addr_r    <= {RA_W{1'b0}};
      dst_addr_r   <= {RA_W{1'b0}};
      if (bubble_cnt_r != CNT_MAX) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end else if (!stall_i) begin
      valid_r      <= valid_i;
      ctrl_r       <= ctrl_i;
      pc_add4_r    <= pc_add4_i;
      rs_data_r    <= rs_data_i;
      rt_data_r    <= rt_data_i;
      imm_r        <= imm_i;
      rs_addr_r    <= rs_addr_i;
      rt_addr_r    <= rt_addr_i;
      rd_addr_r    <= rd_addr_i;
      dst_addr_r   <= dst_sel_s;
      bubble_cnt_r <= bubble_cnt_r;
    end else begin
      valid_r      <= valid_r;
      ctrl_r       <= ctrl_r;
      pc_add4_r    <= pc_add4_r;
      rs_data_r    <= rs_data_r;
      rt_data_r    <= rt_data_r;
      imm_r        <= imm_r;
      rs_addr_r    <= rs_addr_r;
      rt_addr_r    <= rt_addr_r;
      rd_addr_r    <= rd_addr_r;
      dst_addr_r   <= dst_addr_r;
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  // Control word is packed {WB, M, ALUSrc, ALUop, RegDst} from MSB to LSB
  assign valid_o      = valid_r;
  assign wb_o         = ctrl_r[CW-1 -: WB_W];
  assign m_o          = ctrl_r[CW-1-WB_W -: M_W];
  assign alu_src_o    = ctrl_r[ALUOP_W+1];
  assign alu_op_o     = ctrl_r[ALUOP_W:1];
  assign reg_dst_o    = ctrl_r[0];
  assign pc_add4_o    = pc_add4_r;
  assign rs_data_o    = rs_data_r;
  assign rt_data_o    = rt_data_r;
  assign imm_o        = imm_r;
  assign rs_addr_o    = rs_addr_r;
  assign rt_addr_o    = rt_addr_r;
  assign rd_addr_o    = rd_addr_r;
  assign dst_addr_o   = dst_addr_r;
  assign bubble_cnt_o = bubble_cnt_r;

endmodule

// File: tb/tb_pipeline_id_ex_reg.sv
// Bench for pipeline_id_ex_reg: directed vector table, hand-written corner sequences
// and a randomized run against an independent reference model.
module tb_pipeline_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0, sat_flush = 1'b0;
  logic [7:0]  ctrl = 8'h00;
  logic [31:0] pc = 32'h0, rs_d = 32'h0, rt_d = 32'h0, imm = 32'h0;
  logic [4:0]  rs_a = 5'd0, rt_a = 5'd0, rd_a = 5'd0;

  logic        valid_o, alu_src_o, reg_dst_o;
  logic [1:0]  wb_o, m_o, alu_op_o;
  logic [31:0] pc_o, rs_d_o, rt_d_o, imm_o;
  logic [4:0]  rs_a_o, rt_a_o, rd_a_o, dst_o;
  logic [15:0] cnt_o;

  logic        s_valid_o, s_alu_src_o, s_reg_dst_o;
  logic [1:0]  s_wb_o, s_m_o, s_alu_op_o;
  logic [31:0] s_pc_o, s_rs_d_o, s_rt_d_o, s_imm_o;
  logic [4:0]  s_rs_a_o, s_rt_a_o, s_rd_a_o, s_dst_o;
  logic [2:0]  s_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_id_ex_reg u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .pc_add4_i(pc), .rs_data_i(rs_d), .rt_data_i(rt_d), .imm_i(imm),
    .rs_addr_i(rs_a), .rt_addr_i(rt_a), .rd_addr_i(rd_a),
    .valid_o(valid_o), .wb_o(wb_o), .m_o(m_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
    .reg_dst_o(reg_dst_o), .pc_add4_o(pc_o), .rs_data_o(rs_d_o), .rt_data_o(rt_d_o),
    .imm_o(imm_o), .rs_addr_o(rs_a_o), .rt_addr_o(rt_a_o), .rd_addr_o(rd_a_o),
    .dst_addr_o(dst_o), .bubble_cnt_o(cnt_o)
  );

  pipeline_id_ex_reg #(.CNT_W(3)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(sat_flush), .valid_i(valid),
    .ctrl_i(ctrl), .pc_add4_i(pc), .rs_data_i(rs_d), .rt_data_i(rt_d), .imm_i(imm),
    .rs_addr_i(rs_a), .rt_addr_i(rt_a), .rd_addr_i(rd_a),
    .valid_o(s_valid_o), .wb_o(s_wb_o), .m_o(s_m_o), .alu_src_o(s_alu_src_o),
    .alu_op_o(s_alu_op_o), .reg_dst_o(s_reg_dst_o), .pc_add4_o(s_pc_o),
    .rs_data_o(s_rs_d_o), .rt_data_o(s_rt_d_o), .imm_o(s_imm_o), .rs_addr_o(s_rs_a_o),
    .rt_addr_o(s_rt_a_o), .rd_addr_o(s_rd_a_o), .dst_addr_o(s_dst_o), .bubble_cnt_o(s_cnt_o)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [7:0]  ctrl;
    logic [31:0] rs;
    logic [4:0]  rt, rd;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [4:0]  exp_dst;
    logic [31:0] exp_rs;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [7];

  // reference model state
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_pc, m_rs, m_rt, m_imm;
  logic [4:0]  m_rsa, m_rta, m_rda, m_dst;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_out();
    return {wb_o, m_o, alu_src_o, alu_op_o, reg_dst_o};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] r, input logic [4:0] t,
                       input logic [4:0] d);
    ctrl = c; rs_d = r; rt_d = ~r; imm = r ^ 32'h0F0F_0F0F; pc = r + 32'd4;
    rs_a = r[4:0]; rt_a = t; rd_a = d;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h9D, 32'h1234_5678, 5'd9,  5'd17, 1'b1, 8'h9D, 5'd17, 32'h1234_5678, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'hE2, 32'hAAAA_5555, 5'd3,  5'd20, 1'b1, 8'hE2, 5'd3,  32'hAAAA_5555, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'hFF, 32'h0BAD_0BAD, 5'd4,  5'd5,  1'b0, 8'hFF, 5'd5,  32'h0BAD_0BAD, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 32'hDEAD_BEEF, 5'd6,  5'd7,  1'b0, 8'hFF, 5'd5,  32'h0BAD_0BAD, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h9D, 32'h1111_2222, 5'd1,  5'd2,  1'b0, 8'h00, 5'd0,  32'h0,         16'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h9D, 32'h3333_4444, 5'd1,  5'd2,  1'b0, 8'h00, 5'd0,  32'h0,         16'd2};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h9D, 32'h1234_5678, 5'd9,  5'd17, 1'b1, 8'h9D, 5'd17, 32'h1234_5678, 16'd2};

    // Reset: load garbage, then assert reset mid-stall between edges
    drive(8'hFF, 32'hFEED_FACE, 5'd31, 5'd30);
    valid = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("pre_reset_valid", valid_o, 1'b1);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_all", {valid_o, ctrl_out(), pc_o, rs_d_o, rt_d_o, imm_o, rs_a_o,
                            rt_a_o, rd_a_o, dst_o, cnt_o}, 256'd0);
    step();
    chk("reset_held_edge", {valid_o, ctrl_out(), rs_d_o, dst_o, cnt_o, s_cnt_o}, 256'd0);
    rst_n = 1'b1;
    stall = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush; valid = vecs[i].valid;
      drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      step();
      chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ctrl", i), ctrl_out(), vecs[i].exp_ctrl);
      chk($sformatf("vec%0d_dst", i), dst_o, vecs[i].exp_dst);
      chk($sformatf("vec%0d_rs", i), rs_d_o, vecs[i].exp_rs);
      chk($sformatf("vec%0d_cnt", i), cnt_o, vecs[i].exp_cnt);
    end
    chk("load_fields", {wb_o, m_o, alu_src_o, alu_op_o, reg_dst_o, rt_a_o, rd_a_o},
        {2'b10, 2'b01, 1'b1, 2'b10, 1'b1, 5'd9, 5'd17});
    flush = 1'b0;

    // Stall holds A for 3 cycles while B is presented, B appears after release
    stall = 1'b1;
    drive(8'hE2, 32'hCAFE_F00D, 5'd12, 5'd13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold%0d", i), {valid_o, rs_d_o, dst_o, pc_o}, {1'b1, 32'h1234_5678, 5'd17, 32'h1234_567C});
    end
    stall = 1'b0;
    step();
    chk("stall_release", {valid_o, rs_d_o, dst_o, rt_d_o}, {1'b1, 32'hCAFE_F00D, 5'd12, 32'h3501_0FF2});

    // Flush together with stall zeroes everything and counts
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_stall_zero", {valid_o, wb_o, m_o, pc_o, rs_d_o, rt_d_o, imm_o, rs_a_o,
                             rt_a_o, rd_a_o, dst_o}, 256'd0);
    chk("flush_stall_cnt", cnt_o, 16'd3);
    stall = 1'b0; flush = 1'b0;

    // Saturation on the 3-bit counter instance
    sat_flush = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("sat_cnt%0d", i), s_cnt_o, (i < 7) ? 3'(i + 1) : 3'd7);
    end
    sat_flush = 1'b0;
    step();
    chk("sat_hold", s_cnt_o, 3'd7);

    // Randomized run against the reference model
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_valid = 1'b0; m_ctrl = 8'h00; m_pc = 32'h0; m_rs = 32'h0; m_rt = 32'h0; m_imm = 32'h0;
    m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0; m_dst = 5'd0; m_cnt = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      valid = $urandom_range(1) == 1;
      ctrl = 8'($urandom); pc = $urandom; rs_d = $urandom; rt_d = $urandom; imm = $urandom;
      rs_a = 5'($urandom); rt_a = 5'($urandom); rd_a = 5'($urandom);
      if (flush) begin
        m_valid = 1'b0; m_ctrl = 8'h00; m_pc = 32'h0; m_rs = 32'h0; m_rt = 32'h0;
        m_imm = 32'h0; m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0; m_dst = 5'd0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (!stall) begin
        m_valid = valid; m_ctrl = ctrl; m_pc = pc; m_rs = rs_d; m_rt = rt_d; m_imm = imm;
        m_rsa = rs_a; m_rta = rt_a; m_rda = rd_a; m_dst = ctrl[0] ? rd_a : rt_a;
      end
      step();
      chk($sformatf("rand%0d", n),
          {valid_o, ctrl_out(), pc_o, rs_d_o, rt_d_o, imm_o, rs_a_o, rt_a_o, rd_a_o, dst_o, cnt_o},
          {m_valid, m_ctrl, m_pc, m_rs, m_rt, m_imm, m_rsa, m_rta, m_rda, m_dst, m_cnt});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
